// File: rtl/us_coloring_loader.sv
// us_coloring_loader
// Upstream feeder for the 48-region US map-colouring checker. Collects one
// region colour per stream write into a registered 96-bit assignment vector,
// then on frame end samples the checker verdict together with coverage and
// index-range integrity, and hands out one result word over valid/ready.
//
// Optional build macro: US_COLORING_LOADER_DUPCHK_EN
//   defined   -> a repeated index within one frame flags an error
//   undefined -> repeated indices are accepted, last write wins
module us_coloring_loader #(
  parameter int NUM_REGIONS = 48,
  parameter int COLOR_W     = 2,
  parameter int IDX_W       = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IDX_W-1:0]               in_idx,
  input  logic [COLOR_W-1:0]             in_color,
  input  logic                           in_last,
  output logic [NUM_REGIONS*COLOR_W-1:0] coloring,
  input  logic                           chk_valid,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           res_ok,
  output logic [IDX_W-1:0]               res_missing,
  output logic                           res_err
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  state_t                 state;
  logic [NUM_REGIONS-1:0] mask;
  logic                   err;
  logic                   accept;
  logic                   idx_ok;
  logic                   dup_hit;

  // Number of regions not yet covered in the current frame.
  function automatic logic [IDX_W-1:0] missing_count(input logic [NUM_REGIONS-1:0] m);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (m[i]) cnt++;
    end
    return IDX_W'(NUM_REGIONS - cnt);
  endfunction

  assign accept = in_valid && in_ready;
  assign idx_ok = (32'(in_idx) < NUM_REGIONS);

`ifdef US_COLORING_LOADER_DUPCHK_EN
  assign dup_hit = mask[in_idx];
`else
  assign dup_hit = 1'b0;
`endif

  // Frame FSM: collects writes, samples the checker verdict, holds the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      coloring    <= '0;
      mask        <= '0;
      err         <= 1'b0;
      res_valid   <= 1'b0;
      res_ok      <= 1'b0;
      res_missing <= '0;
      res_err     <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (idx_ok) begin
              coloring[in_idx*COLOR_W +: COLOR_W] <= in_color;
              mask[in_idx]                        <= 1'b1;
              if (dup_hit) err <= 1'b1;
            end else begin
              // Out-of-range writes are dropped but still complete the handshake.
              err <= 1'b1;
            end
            if (in_last) begin
              state    <= CHECK;
              in_ready <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        CHECK: begin
          // coloring has been stable for a full cycle, so the verdict has settled.
          res_ok      <= chk_valid && (&mask) && !err;
          res_missing <= missing_count(mask);
          res_err     <= err;
          res_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            // coloring is kept so the checker still sees the last candidate.
            res_valid <= 1'b0;
            mask      <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_us_coloring_loader.sv
// tb_us_coloring_loader
// Directed bench for us_coloring_loader. The checker is stood in for by a
// single border rule (WA idx 44 vs OR idx 34 must differ), enough to make the
// loader's verdict sampling observable. Base colouring is colour = idx % 4.
module tb_us_coloring_loader;

  localparam int NR = 48;
  localparam int CW = 2;
  localparam int IW = 6;
  localparam int WA = 44;
  localparam int OR = 34;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IW-1:0]     in_idx = '0;
  logic [CW-1:0]     in_color = '0;
  logic              in_last = 1'b0;
  logic [NR*CW-1:0]  coloring;
  logic              chk_valid;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic              res_ok;
  logic [IW-1:0]     res_missing;
  logic              res_err;

  logic [NR*CW-1:0]  exp_col = '0;
  int                nvec = 0;
  int                nmis = 0;

  us_coloring_loader #(.NUM_REGIONS(NR), .COLOR_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_color(in_color), .in_last(in_last),
    .coloring(coloring), .chk_valid(chk_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_ok(res_ok), .res_missing(res_missing), .res_err(res_err)
  );

  always #5 clk = ~clk;

  assign chk_valid = (coloring[2*WA +: 2] != coloring[2*OR +: 2]);

  task automatic chk(input string tag, input logic [NR*CW-1:0] obs, input logic [NR*CW-1:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input int col, input bit last);
    int n;
    logic [31:0] c;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("wr_ready_timeout", in_ready, 1'b1);
    c        = col;
    in_valid = 1'b1;
    in_idx   = IW'(idx);
    in_color = c[CW-1:0];
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (idx < NR) exp_col[2*idx +: 2] = c[CW-1:0];
  endtask

  task automatic load_frame(input int skip, input int wa_c, input int or_c,
                            input bit dup_ca, input bit bad_tail);
    int col;
    for (int i = 0; i < NR; i++) begin
      if (i != skip) begin
        col = (i == WA) ? wa_c : (i == OR) ? or_c : i % 4;
        wr(i, col, (i == NR - 1) && !bad_tail);
        if (i == 3 && dup_ca) wr(3, 3, 1'b0);
      end
    end
    if (bad_tail) wr(50, 1, 1'b1);
  endtask

  // Called right after the in_last handshake edge (the CHECK cycle).
  task automatic expect_result(input bit ok, input int miss, input bit err);
    chk("check_in_ready", in_ready, 1'b0);
    chk("check_res_valid", res_valid, 1'b0);
    @(posedge clk); #1;
    chk("res_valid", res_valid, 1'b1);
    chk("res_ok", res_ok, ok);
    chk("res_missing", res_missing, miss);
    chk("res_err", res_err, err);
    chk("coloring", coloring, exp_col);
    chk("done_in_ready", in_ready, 1'b0);
  endtask

  task automatic take;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("res_valid_clr", res_valid, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    // asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_coloring", coloring, '0);
    chk("rst_res_ok", res_ok, 1'b0);
    chk("rst_res_missing", res_missing, '0);
    chk("rst_res_err", res_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // legal frame
    load_frame(-1, 0, 2, 1'b0, 1'b0);
    expect_result(1'b1, 0, 1'b0);
    take();

    // WA/OR border conflict
    load_frame(-1, 1, 1, 1'b0, 1'b0);
    expect_result(1'b0, 0, 1'b0);
    take();

    // incomplete: idx 42 never written
    load_frame(42, 0, 2, 1'b0, 1'b0);
    expect_result(1'b0, 1, 1'b0);
    take();

    // full legal frame, then an out-of-range write carrying in_last
    load_frame(-1, 0, 2, 1'b0, 1'b1);
    expect_result(1'b0, 0, 1'b1);
    take();

    // backpressure: result held, writes offered during DONE are ignored
    load_frame(-1, 0, 2, 1'b0, 1'b0);
    expect_result(1'b1, 0, 1'b0);
    in_valid = 1'b1; in_idx = 6'd0; in_color = 2'd3; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_res_valid", res_valid, 1'b1);
      chk("hold_res_ok", res_ok, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_coloring", coloring, exp_col);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take();

    // CA written twice
    load_frame(-1, 0, 2, 1'b1, 1'b0);
`ifdef US_COLORING_LOADER_DUPCHK_EN
    expect_result(1'b0, 0, 1'b1);
`else
    expect_result(1'b1, 0, 1'b0);
`endif
    take();

    // reset mid-LOAD aborts the frame
    for (int i = 0; i < 10; i++) wr(i, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_col = '0;
    chk("mid_rst_coloring", coloring, exp_col);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("after_rst_no_result", res_valid, 1'b0);
    end

    // single write with in_last straight from IDLE
    wr(5, 2, 1'b1);
    expect_result(1'b0, 47, 1'b0);
    take();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
